// File: rtl/hilo_div_sequencer_if.sv
// hilo_div_sequencer_if
// Groups the decode-stage request and the sequencer's control outputs so the
// decode side (master) and the HI/LO divide sequencer (slave) share one bundle.
interface hilo_div_sequencer_if;
    logic       id_valid;
    logic [5:0] id_opcode;
    logic [5:0] id_funct;
    logic       ex_advance;
    logic       stall_id;
    logic       div_start;
    logic       hilo_write;
    logic       busy;

    modport master (
        output id_valid,
        output id_opcode,
        output id_funct,
        output ex_advance,
        input  stall_id,
        input  div_start,
        input  hilo_write,
        input  busy
    );

    modport slave (
        input  id_valid,
        input  id_opcode,
        input  id_funct,
        input  ex_advance,
        output stall_id,
        output div_start,
        output hilo_write,
        output busy
    );
endinterface

// File: rtl/hilo_div_sequencer.sv
// hilo_div_sequencer
// Sequences a fixed-latency divider and the HI/LO register write, and holds
// the decode stage when a DIV or MFHI/MFLO would collide with a divide in flight.
// A DIV issued in cycle T pulses div_start in T, and hilo_write fires in
// T+DIV_CYCLES exactly; a new DIV may issue in that same write cycle.
// Optional feature macro: HILO_BYPASS_EN -- when defined, MFHI/MFLO is not
// held in the write cycle because the result is forwarded there; when
// undefined, MFHI/MFLO is held through the write cycle.
// Reset is synchronous and active-low; outputs are forced low while it is held.
module hilo_div_sequencer #(
    parameter int DIV_CYCLES = 32
) (
    input  logic                   clk,
    input  logic                   rst_b,
    hilo_div_sequencer_if.slave    bus
);

    localparam int CNT_W = $clog2(DIV_CYCLES) + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] FN_DIV     = 6'h1A;
    localparam logic [5:0] FN_MFHI    = 6'h10;
    localparam logic [5:0] FN_MFLO    = 6'h12;

`ifdef HILO_BYPASS_EN
    localparam logic BYPASS_EN = 1'b1;
`else
    localparam logic BYPASS_EN = 1'b0;
`endif

    // Decode helpers kept as functions so the instruction classes read plainly.
    function automatic logic f_is_div(input logic v, input logic [5:0] op, input logic [5:0] fn);
        return v & (op == OP_SPECIAL) & (fn == FN_DIV);
    endfunction

    function automatic logic f_is_mfhilo(input logic v, input logic [5:0] op, input logic [5:0] fn);
        return v & (op == OP_SPECIAL) & ((fn == FN_MFHI) | (fn == FN_MFLO));
    endfunction

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             is_div_s;
    logic             is_mfhilo_s;
    logic             stall_s;
    logic             issue_s;

    // Classify the decode-stage instruction and decide whether it must be held.
    always_comb begin
        is_div_s    = f_is_div(bus.id_valid, bus.id_opcode, bus.id_funct);
        is_mfhilo_s = f_is_mfhilo(bus.id_valid, bus.id_opcode, bus.id_funct);
        stall_s     = 1'b0;
        case (state_q)
            ST_IDLE: stall_s = 1'b0;
            ST_BUSY: stall_s = is_div_s | is_mfhilo_s;
            // A DIV may issue in the write cycle; only an unbypassed HI/LO read waits.
            ST_DONE: stall_s = is_mfhilo_s & ~BYPASS_EN;
            default: stall_s = 1'b0;
        endcase
        issue_s = is_div_s & bus.ex_advance & ~stall_s;
    end

    // Next-state and latency counter: load on issue, count down, never wrap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (issue_s) begin
                    state_d = ST_BUSY;
                    cnt_d   = CNT_LOAD;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end
            end
            ST_BUSY: begin
                if (cnt_q <= CNT_ONE) begin
                    state_d = ST_DONE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = ST_BUSY;
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            ST_DONE: begin
                if (issue_s) begin
                    state_d = ST_BUSY;
                    cnt_d   = CNT_LOAD;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output decode; everything is held low while reset is asserted.
    always_comb begin
        bus.stall_id   = rst_b & stall_s;
        bus.div_start  = rst_b & issue_s;
        bus.hilo_write = rst_b & (state_q == ST_DONE);
        bus.busy       = rst_b & ((state_q == ST_BUSY) | (state_q == ST_DONE));
    end

endmodule

// File: tb/tb_hilo_div_sequencer.sv
// tb_hilo_div_sequencer
// Directed vectors with hand-computed per-cycle expectations for
// {stall_id, div_start, hilo_write, busy}; the stimulus pushes them into a
// scoreboard queue and a negedge monitor pops and compares.
module tb_hilo_div_sequencer;

    localparam int DC = 4;

    localparam logic [5:0] OP_SP  = 6'h00;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] FN_DIV = 6'h1A;
    localparam logic [5:0] FN_MFH = 6'h10;
    localparam logic [5:0] FN_MFL = 6'h12;
    localparam logic [5:0] FN_ADU = 6'h21;
    localparam logic [5:0] FN_NOP = 6'h00;

    logic clk = 1'b0;
    logic rst_b = 1'b0;

    always #5 clk = ~clk;

    hilo_div_sequencer_if bus_if ();

    hilo_div_sequencer #(.DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus_if)
    );

    typedef struct {
        string      tag;
        logic [3:0] exp;   // {stall_id, div_start, hilo_write, busy}
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input string fld, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s %s actual=%0b required=%0b t=%0t", tag, fld, act, exp, $time);
        end
    endtask

    // Monitor: compare the presented outputs against the oldest expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk(e.tag, "stall_id",   bus_if.stall_id,   e.exp[3]);
            chk(e.tag, "div_start",  bus_if.div_start,  e.exp[2]);
            chk(e.tag, "hilo_write", bus_if.hilo_write, e.exp[1]);
            chk(e.tag, "busy",       bus_if.busy,       e.exp[0]);
        end
    end

    // One clock of stimulus plus the outputs expected during that clock.
    task automatic step(input string tag, input logic rb, input logic v,
                        input logic [5:0] op, input logic [5:0] fn,
                        input logic adv, input logic [3:0] exp);
        exp_t e;
        @(posedge clk);
        #1;
        rst_b             = rb;
        bus_if.id_valid   = v;
        bus_if.id_opcode  = op;
        bus_if.id_funct   = fn;
        bus_if.ex_advance = adv;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic nop(input string tag, input logic [3:0] exp);
        step(tag, 1'b1, 1'b0, OP_SP, FN_NOP, 1'b1, exp);
    endtask

    task automatic div_i(input string tag, input logic adv, input logic [3:0] exp);
        step(tag, 1'b1, 1'b1, OP_SP, FN_DIV, adv, exp);
    endtask

    logic [3:0] mflo_c4;

    initial begin
`ifdef HILO_BYPASS_EN
        mflo_c4 = 4'b0011;
`else
        mflo_c4 = 4'b1011;
`endif
        bus_if.id_valid   = 1'b0;
        bus_if.id_opcode  = OP_SP;
        bus_if.id_funct   = FN_NOP;
        bus_if.ex_advance = 1'b0;

        // Reset state, including a DIV presented while reset is held.
        step("rst0", 1'b0, 1'b0, OP_SP, FN_NOP, 1'b0, 4'b0000);
        step("rst1", 1'b0, 1'b1, OP_SP, FN_DIV, 1'b1, 4'b0000);

        // Single divide: start at 0, busy 1..4, write at 4.
        div_i("a_c0", 1'b1, 4'b0100);
        nop("a_c1", 4'b0001);
        nop("a_c2", 4'b0001);
        nop("a_c3", 4'b0001);
        nop("a_c4", 4'b0011);
        nop("a_c5", 4'b0000);

        // MFLO behind a divide.
        div_i("b_c0", 1'b1, 4'b0100);
        nop("b_c1", 4'b0001);
        step("b_c2", 1'b1, 1'b1, OP_SP, FN_MFL, 1'b1, 4'b1001);
        step("b_c3", 1'b1, 1'b1, OP_SP, FN_MFL, 1'b1, 4'b1001);
        step("b_c4", 1'b1, 1'b1, OP_SP, FN_MFL, 1'b1, mflo_c4);
        step("b_c5", 1'b1, 1'b1, OP_SP, FN_MFL, 1'b1, 4'b0000);

        // Back-to-back divides: second issues in the write cycle.
        div_i("c_c0", 1'b1, 4'b0100);
        div_i("c_c1", 1'b1, 4'b1001);
        div_i("c_c2", 1'b1, 4'b1001);
        div_i("c_c3", 1'b1, 4'b1001);
        div_i("c_c4", 1'b1, 4'b0111);
        nop("c_c5", 4'b0001);
        nop("c_c6", 4'b0001);
        nop("c_c7", 4'b0001);
        nop("c_c8", 4'b0011);
        nop("c_c9", 4'b0000);

        // Reset in the middle of a divide abandons it.
        div_i("d_c0", 1'b1, 4'b0100);
        nop("d_c1", 4'b0001);
        step("d_c2", 1'b0, 1'b0, OP_SP, FN_NOP, 1'b1, 4'b0000);
        nop("d_c3", 4'b0000);
        nop("d_c4", 4'b0000);
        nop("d_c5", 4'b0000);
        nop("d_c6", 4'b0000);

        // Non-advancing divide does not issue until ex_advance rises.
        div_i("e_c0", 1'b0, 4'b0000);
        div_i("e_c1", 1'b0, 4'b0000);
        div_i("e_c2", 1'b0, 4'b0000);
        div_i("e_c3", 1'b1, 4'b0100);
        nop("e_c4", 4'b0001);
        nop("e_c5", 4'b0001);
        nop("e_c6", 4'b0001);
        nop("e_c7", 4'b0011);
        nop("e_c8", 4'b0000);

        // Unrelated instructions pass through during BUSY; MFHI is held.
        div_i("f_c0", 1'b1, 4'b0100);
        step("f_c1", 1'b1, 1'b1, OP_SP, FN_ADU, 1'b1, 4'b0001);
        step("f_c2", 1'b1, 1'b1, OP_LW, FN_NOP, 1'b1, 4'b0001);
        step("f_c3", 1'b1, 1'b1, OP_SP, FN_MFH, 1'b0, 4'b1001);
        div_i("f_c4", 1'b0, 4'b0011);
        nop("f_c5", 4'b0000);

        repeat (2) @(posedge clk);
        #1;
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard bound on the run in case the stimulus ever stops advancing.
    initial begin
        #20000;
        bad++;
        $display("FAIL watchdog actual=timeout required=completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
